dec_pingpong_sched: RTL and testbench
=====================================

# dec_pingpong_sched

Frame scheduler for the two-lane ping-pong RS decoder datapath. It dispatches whole input frames alternately to decoder lane 0 and lane 1, and records lane order in a small order FIFO. It then merges the two 8-bit decoder output streams back into a single stream in strict frame order, packed into 32-bit words with byte enables. It sits between the receive byte stream and the two `rs_decoder_0` instances, and replaces the priority-based output select so that lane outputs can never interleave.

## Interface
- `ORDER_DEPTH`, 4: maximum frames in flight, accepted but not yet fully output; power of 2, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `core_clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 8, `s_axis_tvalid` in 1, `s_axis_tlast` in 1, `s_axis_tready` out 1: encoded byte input.
- `dec0_s_tdata` out 8, `dec0_s_tvalid` out 1, `dec0_s_tlast` out 1, `dec0_s_tready` in 1: lane 0 decoder input.
- `dec1_s_tdata`, `dec1_s_tvalid`, `dec1_s_tlast`, `dec1_s_tready`: lane 1, same as lane 0.
- `dec0_m_tdata` in 8, `dec0_m_tvalid` in 1, `dec0_m_tlast` in 1, `dec0_m_tready` out 1: lane 0 decoder output.
- `dec1_m_tdata`, `dec1_m_tvalid`, `dec1_m_tlast`, `dec1_m_tready`: lane 1, same as lane 0.
- `m_axis_tdata` out 32, `m_axis_tkeep` out 4, `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tready` in 1: packed output.
- `in_flight` out $clog2(ORDER_DEPTH)+1: order FIFO occupancy.
- `frames_in` out CNT_W, `frames_out` out CNT_W: statistics counters.

## Operation
- **Dispatch**
  - `wr_lane` register, reset 0, toggles on an input handshake with `tlast`.
  - Input is routed combinationally to `dec<wr_lane>_s_*`. The other lane sees `tvalid`=0, `tdata`=0 and `tlast`=0.
  - `sof` flag, reset 1: set after a `tlast` handshake, cleared on any other handshake.
  - `s_axis_tready` = `dec<wr_lane>_s_tready` && !(`sof` && order FIFO full). Only a frame's first beat is back-pressured by the FIFO.
  - On the first-beat handshake, `wr_lane` is pushed into the order FIFO.
- **Merge**
  - The head lane is the order FIFO head, valid when the FIFO is non-empty.
  - Only the head lane may see `m_tready`=1; the non-head lane's `m_tready` is always 0.
  - A head-lane `tlast` handshake pops the order FIFO. The new head is usable the next cycle.
- **Packer**
  - Accumulator holds 0–3 bytes with `acc_cnt`. Byte k of a word goes to `[8k+7:8k]` (little-endian).
  - A byte completes the word when `acc_cnt`==3 or the byte carries `tlast`.
  - Head-lane `m_tready` = head valid && (!completing || `out_free`), where `out_free` = !`m_axis_tvalid` || `m_axis_tready`.
  - On completion the output register loads {byte, acc}, with unfilled bytes 0. `m_axis_tkeep` = (1<<(acc_cnt+1))-1. `m_axis_tlast` = the byte's `tlast`. `acc_cnt` returns to 0.
  - A partial word is emitted only at frame end; words never span frames.
- **Reset values:** all `tvalid`/`tready`/`tlast`/`tdata`/`tkeep` outputs 0, `in_flight` 0, counters 0, `wr_lane` 0, `sof` 1, `acc_cnt` 0.
- **Reset mid-frame:** all state is discarded. The decoder IP must be reset in the same window; this block does not reset it.

## Timing
- Dispatch is combinational, with zero added latency.
- Merge: a completing byte accepted in cycle N gives `m_axis_tvalid`=1 in cycle N+1.
- The output register holds data stable while `tvalid` && !`tready`.
- Full throughput is 1 byte/cycle in. Out is 1 word per 4 cycles with no bubbles.
- Same-cycle push and pop: occupancy is unchanged. A push into a full FIFO with a simultaneous pop is allowed.
- Head is lane 0 while lane 1 has data: lane 1 is stalled indefinitely until the lane 0 `tlast`.

## Configuration
- `DEC_SCHED_STATS_EN` defined:
  - `frames_in` increments on each first-beat handshake.
  - `frames_out` increments on each `m_axis` handshake with `tlast`.
  - Both wrap modulo 2^CNT_W.
- Not defined: both ports are tied to 0 and no counter flops exist. `in_flight` is always present.

## Structure
- Package `dec_sched_pkg`:
  - `lane_t` (LANE0, LANE1).
  - `BYTES_PER_WORD`=4.
  - `KEEP_W`=4.
- Sub-module `dec_sched_order_fifo`: ORDER_DEPTH×1-bit synchronous FIFO with push/pop/full/empty/count, async active-low reset.

## Test plan
- **Single frame:** frame of bytes 01..06 → dec0 receives 01..06 with `tlast` on 06. dec0 returns them → `m_axis` gives 0x04030201 keep 0xF, then 0x00000605 keep 0x3 `tlast`=1.
- **Out-of-order completion:** frame A (lane 0, 4 bytes), frame B (lane 1, 4 bytes); dec1 output valid before dec0 → `dec1_m_tready`=0 until A's `tlast` handshake. Output is A's word then B's word.
- **Order FIFO full:** 4 frames in flight, no decoder output → 5th frame first beat sees `s_axis_tready`=0 with `in_flight`=4. One frame drains → accepted the following cycle.
- **Output back-pressure:** `m_axis_tready`=0 for 10 cycles mid-frame → `m_axis_tdata` stable and head-lane `m_tready` drops on the completing byte. No byte lost or duplicated.
- **Reset mid-frame:** `rst_n` low on the 3rd beat of a lane 1 frame → all outputs 0 immediately. After release, the next frame goes to lane 0 and `in_flight`=0.
- **Statistics:** with `DEC_SCHED_STATS_EN`, 3 full frames → `frames_in`=3, `frames_out`=3. Without the macro, both read 0.

Source files
------------

// File: rtl/dec_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : dec_sched_pkg
//  Purpose   : Shared types and constants for the ping-pong frame scheduler.
//  Revision  : 1.0 - initial release
// ============================================================================
package dec_sched_pkg;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int KEEP_W         = 4;

  // Contiguous byte-enable mask covering bytes 0..cnt of an output word.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] cnt);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      m[i] = (i <= int'(cnt));
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_sched_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : dec_sched_order_fifo
//  Purpose   : DEPTH x 1-bit synchronous FIFO recording the lane of each
//              frame in flight. A push into a full FIFO is honoured when a
//              pop happens in the same cycle.
//  Revision  : 1.0 - initial release
// ============================================================================
module dec_sched_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     core_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  logic [DEPTH-1:0]  mem_q, mem_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_FW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec_pingpong_sched.sv
`default_nettype none
// ============================================================================
//  Module    : dec_pingpong_sched
//  Purpose   : Dispatches whole input frames alternately to two decoder lanes
//              and merges the lane outputs back in strict frame order, packed
//              little-endian into 32-bit words with byte enables.
//  Options   : DEC_SCHED_STATS_EN - enables frames_in / frames_out counters.
//  Revision  : 1.0 - initial release
// ============================================================================
module dec_pingpong_sched
  import dec_sched_pkg::*;
#(
  parameter int ORDER_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          core_clk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [7:0]                    dec0_s_tdata,
  output logic                          dec0_s_tvalid,
  output logic                          dec0_s_tlast,
  input  logic                          dec0_s_tready,
  output logic [7:0]                    dec1_s_tdata,
  output logic                          dec1_s_tvalid,
  output logic                          dec1_s_tlast,
  input  logic                          dec1_s_tready,
  input  logic [7:0]                    dec0_m_tdata,
  input  logic                          dec0_m_tvalid,
  input  logic                          dec0_m_tlast,
  output logic                          dec0_m_tready,
  input  logic [7:0]                    dec1_m_tdata,
  input  logic                          dec1_m_tvalid,
  input  logic                          dec1_m_tlast,
  output logic                          dec1_m_tready,
  output logic [31:0]                   m_axis_tdata,
  output logic [KEEP_W-1:0]             m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(ORDER_DEPTH):0]  in_flight,
  output logic [CNT_W-1:0]              frames_in,
  output logic [CNT_W-1:0]              frames_out
);

  localparam int ACC_W = 8 * (BYTES_PER_WORD - 1);

  lane_t             wr_lane_q, wr_lane_d;
  logic              sof_q, sof_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [31:0]       m_data_q, m_data_d;
  logic [KEEP_W-1:0] m_keep_q, m_keep_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;

  logic              fifo_full, fifo_empty, fifo_head;
  logic              sel_tready, in_hs, push, pop;
  lane_t             head_lane;
  logic              head_valid, head_tvalid, head_tlast;
  logic [7:0]        head_tdata;
  logic              completing, out_free, head_ready, byte_hs;

  // ---- Dispatch: the input is muted while reset is asserted ----
  assign sel_tready    = (wr_lane_q == LANE1) ? dec1_s_tready : dec0_s_tready;
  assign s_axis_tready = rst_n && sel_tready && !(sof_q && fifo_full);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign push          = in_hs && sof_q;

  // Route the input beat to the lane owning the current frame.
  always_comb begin
    dec0_s_tvalid = 1'b0;
    dec0_s_tdata  = 8'h00;
    dec0_s_tlast  = 1'b0;
    dec1_s_tvalid = 1'b0;
    dec1_s_tdata  = 8'h00;
    dec1_s_tlast  = 1'b0;
    if (rst_n) begin
      if (wr_lane_q == LANE0) begin
        dec0_s_tvalid = s_axis_tvalid;
        dec0_s_tdata  = s_axis_tdata;
        dec0_s_tlast  = s_axis_tlast;
      end else begin
        dec1_s_tvalid = s_axis_tvalid;
        dec1_s_tdata  = s_axis_tdata;
        dec1_s_tlast  = s_axis_tlast;
      end
    end
  end

  // Frame-boundary tracking: switch lanes after each accepted last beat.
  always_comb begin
    wr_lane_d = wr_lane_q;
    sof_d     = sof_q;
    if (in_hs) begin
      sof_d = s_axis_tlast;
      if (s_axis_tlast) begin
        wr_lane_d = (wr_lane_q == LANE0) ? LANE1 : LANE0;
      end
    end
  end

  dec_sched_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      (wr_lane_q),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (in_flight)
  );

  // ---- Merge: only the lane at the head of the order FIFO is served ----
  assign head_valid  = !fifo_empty;
  assign head_lane   = lane_t'(fifo_head);
  assign head_tvalid = (head_lane == LANE1) ? dec1_m_tvalid : dec0_m_tvalid;
  assign head_tdata  = (head_lane == LANE1) ? dec1_m_tdata  : dec0_m_tdata;
  assign head_tlast  = (head_lane == LANE1) ? dec1_m_tlast  : dec0_m_tlast;

  assign completing    = (acc_cnt_q == 2'(BYTES_PER_WORD - 1)) || head_tlast;
  assign out_free      = !m_valid_q || m_axis_tready;
  assign head_ready    = head_valid && (!completing || out_free);
  assign dec0_m_tready = head_ready && (head_lane == LANE0);
  assign dec1_m_tready = head_ready && (head_lane == LANE1);
  assign byte_hs       = head_ready && head_tvalid;
  assign pop           = byte_hs && head_tlast;

  // Packer: gather bytes, flush a word when full or at frame end.
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
    if (byte_hs) begin
      if (completing) begin
        m_data_d  = {8'h00, acc_q} | (32'(head_tdata) << {acc_cnt_q, 3'b000});
        m_keep_d  = keep_mask(acc_cnt_q);
        m_last_d  = head_tlast;
        m_valid_d = 1'b1;
        acc_d     = '0;
        acc_cnt_d = 2'd0;
      end else begin
        case (acc_cnt_q)
          2'd0:    acc_d[7:0]   = head_tdata;
          2'd1:    acc_d[15:8]  = head_tdata;
          default: acc_d[23:16] = head_tdata;
        endcase
        acc_cnt_d = acc_cnt_q + 2'd1;
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;

  // Dispatch, packer and output registers.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_lane_q <= LANE0;
      sof_q     <= 1'b1;
      acc_q     <= '0;
      acc_cnt_q <= 2'd0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      wr_lane_q <= wr_lane_d;
      sof_q     <= sof_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

`ifdef DEC_SCHED_STATS_EN
  logic [CNT_W-1:0] frames_in_q, frames_in_d;
  logic [CNT_W-1:0] frames_out_q, frames_out_d;

  // Frame counters: accepted first beats and delivered last words.
  always_comb begin
    frames_in_d  = frames_in_q;
    frames_out_d = frames_out_q;
    if (push) begin
      frames_in_d = frames_in_q + CNT_W'(1);
    end
    if (m_valid_q && m_axis_tready && m_last_q) begin
      frames_out_d = frames_out_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_in_q  <= '0;
      frames_out_q <= '0;
    end else begin
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
    end
  end

  assign frames_in  = frames_in_q;
  assign frames_out = frames_out_q;
`else
  assign frames_in  = '0;
  assign frames_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dec_pingpong_sched.sv
`default_nettype none
// ============================================================================
//  Module    : tb_dec_pingpong_sched
//  Purpose   : Self-checking bench for dec_pingpong_sched with emulated
//              decoder lanes and a frame-level reference model.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_dec_pingpong_sched;

  localparam int ORDER_DEPTH = 4;
  localparam int CNT_W       = 16;
`ifdef DEC_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        core_clk = 1'b0;
  logic        rst_n    = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
  logic [7:0]  dec0_s_tdata, dec1_s_tdata;
  logic        dec0_s_tvalid, dec0_s_tlast, dec1_s_tvalid, dec1_s_tlast;
  logic        dec0_s_tready = 0, dec1_s_tready = 0;
  logic [7:0]  dec0_m_tdata = '0, dec1_m_tdata = '0;
  logic        dec0_m_tvalid = 0, dec0_m_tlast = 0, dec1_m_tvalid = 0, dec1_m_tlast = 0;
  logic        dec0_m_tready, dec1_m_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 0;
  logic [$clog2(ORDER_DEPTH):0] in_flight;
  logic [CNT_W-1:0] frames_in, frames_out;

  dec_pingpong_sched #(.ORDER_DEPTH(ORDER_DEPTH), .CNT_W(CNT_W)) dut (
    .core_clk(core_clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .dec0_s_tdata(dec0_s_tdata), .dec0_s_tvalid(dec0_s_tvalid),
    .dec0_s_tlast(dec0_s_tlast), .dec0_s_tready(dec0_s_tready),
    .dec1_s_tdata(dec1_s_tdata), .dec1_s_tvalid(dec1_s_tvalid),
    .dec1_s_tlast(dec1_s_tlast), .dec1_s_tready(dec1_s_tready),
    .dec0_m_tdata(dec0_m_tdata), .dec0_m_tvalid(dec0_m_tvalid),
    .dec0_m_tlast(dec0_m_tlast), .dec0_m_tready(dec0_m_tready),
    .dec1_m_tdata(dec1_m_tdata), .dec1_m_tvalid(dec1_m_tvalid),
    .dec1_m_tlast(dec1_m_tlast), .dec1_m_tready(dec1_m_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .in_flight(in_flight),
    .frames_in(frames_in), .frames_out(frames_out)
  );

  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending input beats {last,data}, emulated decoder
  // lane contents, expected output words {last,keep,data}, observed words.
  logic [8:0]  send_q[$];
  logic [8:0]  lq0[$];
  logic [8:0]  lq1[$];
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int k_in, k_dsr, k_dmv0, k_dmv1, k_mr;
  int started, popped, n_out, hb_pos;
  bit in_sof;
  bit prev_hold;
  logic [36:0] prev_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic knobs(input int a, input int b, input int c, input int d, input int e);
    k_in = a; k_dsr = b; k_dmv0 = c; k_dmv1 = d; k_mr = e;
  endtask

  // Queue one frame and its expected packed words (4 bytes per word, LSB first).
  task automatic add_frame(input int len, input int base, input bit rnd);
    logic [31:0] w;
    logic [3:0]  k;
    logic [7:0]  b;
    logic        l;
    int          n;
    w = '0; k = '0; n = 0;
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(base + i);
      l = (i == len - 1);
      send_q.push_back({l, b});
      w[8*n +: 8] = b;
      k[n] = 1'b1;
      n++;
      if (n == 4 || l) begin
        exp_q.push_back({l, k, w});
        w = '0; k = '0; n = 0;
      end
    end
  endtask

  task automatic drive();
    s_axis_tvalid = (send_q.size() > 0) && (int'($urandom_range(99)) < k_in);
    {s_axis_tlast, s_axis_tdata} = (send_q.size() > 0) ? send_q[0] : 9'h0;
    dec0_s_tready = int'($urandom_range(99)) < k_dsr;
    dec1_s_tready = int'($urandom_range(99)) < k_dsr;
    dec0_m_tvalid = (lq0.size() > 0) && (int'($urandom_range(99)) < k_dmv0);
    {dec0_m_tlast, dec0_m_tdata} = (lq0.size() > 0) ? lq0[0] : 9'h0;
    dec1_m_tvalid = (lq1.size() > 0) && (int'($urandom_range(99)) < k_dmv1);
    {dec1_m_tlast, dec1_m_tdata} = (lq1.size() > 0) ? lq1[0] : 9'h0;
    m_axis_tready = int'($urandom_range(99)) < k_mr;
  endtask

  task automatic sample();
    logic el, hl, hv, htl, comp, hr;
    logic [8:0]  b;
    logic [36:0] e;
    el  = in_sof ? started[0] : ~started[0];
    check("d0_vld", dec0_s_tvalid, s_axis_tvalid && !el);
    check("d1_vld", dec1_s_tvalid, s_axis_tvalid && el);
    check("d0_dat", {dec0_s_tlast, dec0_s_tdata}, el ? 9'h0 : {s_axis_tlast, s_axis_tdata});
    check("d1_dat", {dec1_s_tlast, dec1_s_tdata}, el ? {s_axis_tlast, s_axis_tdata} : 9'h0);
    check("s_rdy", s_axis_tready,
          (el ? dec1_s_tready : dec0_s_tready) && !(in_sof && (started - popped) == ORDER_DEPTH));
    check("inflight", in_flight, started - popped);
    hl   = popped[0];
    hv   = (started != popped);
    htl  = hl ? dec1_m_tlast : dec0_m_tlast;
    comp = (hb_pos % 4 == 3) || htl;
    hr   = hv && (!comp || !m_axis_tvalid || m_axis_tready);
    check("m0_rdy", dec0_m_tready, hr && !hl);
    check("m1_rdy", dec1_m_tready, hr && hl);
    if (prev_hold) begin
      check("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, prev_out});
    end
    if (s_axis_tvalid && s_axis_tready) begin
      b = send_q.pop_front();
      if (el) lq1.push_back(b); else lq0.push_back(b);
      if (in_sof) started++;
      in_sof = b[8];
    end
    if (dec0_m_tvalid && dec0_m_tready) begin
      b = lq0.pop_front();
      hb_pos = b[8] ? 0 : hb_pos + 1;
      if (b[8]) popped++;
    end
    if (dec1_m_tvalid && dec1_m_tready) begin
      b = lq1.pop_front();
      hb_pos = b[8] ? 0 : hb_pos + 1;
      if (b[8]) popped++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      check("exp_avail", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
      end
      obs_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      if (m_axis_tlast) n_out++;
    end
    prev_hold = m_axis_tvalid && !m_axis_tready;
    prev_out  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
  endtask

  task automatic cycle();
    @(posedge core_clk); #1;
    drive();
    @(negedge core_clk);
    sample();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((send_q.size() + lq0.size() + lq1.size() + exp_q.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("timeout", n < budget, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge core_clk); #1;
    rst_n = 1'b0;
    s_axis_tvalid = 1; s_axis_tdata = 8'hA5; s_axis_tlast = 0;
    dec0_s_tready = 1; dec1_s_tready = 1;
    dec0_m_tvalid = 1; dec1_m_tvalid = 1; m_axis_tready = 1;
    #1;
    check("rst_dispatch", {dec0_s_tvalid, dec0_s_tdata, dec0_s_tlast,
                           dec1_s_tvalid, dec1_s_tdata, dec1_s_tlast, s_axis_tready}, 0);
    check("rst_merge", {dec0_m_tready, dec1_m_tready}, 0);
    check("rst_out", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
    check("rst_cnt", {in_flight, frames_in, frames_out}, 0);
    send_q.delete(); lq0.delete(); lq1.delete(); exp_q.delete(); obs_q.delete();
    started = 0; popped = 0; n_out = 0; hb_pos = 0; in_sof = 1; prev_hold = 0;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    s_axis_tvalid = 0; dec0_m_tvalid = 0; dec1_m_tvalid = 0;
    rst_n = 1'b1;
  endtask

  // Make the next frame go to the requested lane.
  task automatic align_lane(input bit lane);
    if (started[0] != lane) begin
      knobs(100, 100, 100, 100, 100);
      add_frame(1, 8'h77, 1'b0);
      run_until_idle(100);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    knobs(100, 100, 100, 100, 100);
    do_reset();

    // Single frame 01..06: held in lane 0 first, then released.
    knobs(100, 100, 0, 0, 100);
    add_frame(6, 8'h01, 1'b0);
    run(10);
    check("single_lane0_bytes", lq0.size(), 6);
    check("single_lane1_bytes", lq1.size(), 0);
    k_dmv0 = 100;
    run_until_idle(50);
    check("single_nwords", obs_q.size(), 2);
    check("single_w0", obs_q[0], {1'b0, 4'hF, 32'h04030201});
    check("single_w1", obs_q[1], {1'b1, 4'h3, 32'h00000605});

    // Out-of-order completion: lane 1 output ready before lane 0.
    align_lane(1'b0);
    obs_q.delete();
    knobs(100, 100, 0, 100, 100);
    add_frame(4, 8'h10, 1'b0);
    add_frame(4, 8'h20, 1'b0);
    run(15);
    check("ooo_inflight", in_flight, 2);
    check("ooo_d1_vld", dec1_m_tvalid, 1'b1);
    check("ooo_d1_stall", dec1_m_tready, 1'b0);
    check("ooo_no_out", obs_q.size(), 0);
    k_dmv0 = 100;
    run_until_idle(50);
    check("ooo_nwords", obs_q.size(), 2);
    check("ooo_first", obs_q[0], {1'b1, 4'hF, 32'h13121110});
    check("ooo_second", obs_q[1], {1'b1, 4'hF, 32'h23222120});

    // Order FIFO full: four frames parked in the decoders, fifth waits.
    knobs(100, 100, 0, 0, 100);
    for (int f = 0; f < 5; f++) add_frame(2, 8'h80 + 4*f, 1'b0);
    run(20);
    check("full_inflight", in_flight, ORDER_DEPTH);
    check("full_rdy", s_axis_tready, 1'b0);
    check("full_pending", send_q.size(), 2);
    knobs(100, 100, 100, 100, 100);
    run_until_idle(100);

    // Output back-pressure in the middle of a long frame.
    knobs(100, 100, 100, 100, 100);
    add_frame(12, 8'h30, 1'b0);
    run(5);
    k_mr = 0;
    run(10);
    check("bp_valid", m_axis_tvalid, 1'b1);
    check("bp_head_stall", {dec0_m_tready, dec1_m_tready}, 2'b00);
    k_mr = 100;
    run_until_idle(100);

    // Reset on the third beat of a lane 1 frame.
    align_lane(1'b1);
    knobs(100, 100, 0, 0, 100);
    add_frame(6, 8'h40, 1'b0);
    guard = 0;
    while (send_q.size() > 4 && guard < 20) begin cycle(); guard++; end
    check("rst_mid_beats", send_q.size(), 4);
    check("rst_mid_lane1", lq1.size(), 2);
    do_reset();
    #1;
    check("post_rst_inflight", in_flight, 0);
    knobs(100, 100, 100, 100, 100);
    add_frame(3, 8'h60, 1'b0);
    cycle();
    check("post_rst_lane0", {dec0_s_tvalid, dec1_s_tvalid}, 2'b10);
    run_until_idle(50);

    // Statistics after three complete frames since reset.
    add_frame(5, 8'h90, 1'b0);
    add_frame(8, 8'hA0, 1'b0);
    run_until_idle(100);
    run(3);
    check("stats_in3", frames_in, STATS ? 16'd3 : 16'd0);
    check("stats_out3", frames_out, STATS ? 16'd3 : 16'd0);

    // Randomized traffic in batches with varying handshake densities.
    for (int bt = 0; bt < 6; bt++) begin
      knobs(30 + $urandom_range(70), 30 + $urandom_range(70), 30 + $urandom_range(70),
            30 + $urandom_range(70), 30 + $urandom_range(70));
      for (int f = 0; f < 5; f++) add_frame(1 + $urandom_range(8), 0, 1'b1);
      run_until_idle(4000);
    end
    knobs(100, 100, 100, 100, 100);
    run(3);
    check("stats_in_final", frames_in, STATS ? CNT_W'(started) : '0);
    check("stats_out_final", frames_out, STATS ? CNT_W'(n_out) : '0);
    check("final_inflight", in_flight, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
